gated_pulse_counter: RTL
========================

Name: gated_pulse_counter

Overview:
- Producer side of the count-display path: counts rising edges of an asynchronous pulse input over fixed gate windows.
- Publishes each completed window's total as a stable `validCount` with a one-cycle `countValid` strobe.
- `validCount` feeds the display latch directly and holds its value between publications, so the display side can sample it on any refresh phase.

Parameters:
- WIDTH, 7, width of the count and of `validCount`; saturation value MAX = 2^WIDTH-1.
- GATE_CYCLES, 16, clock cycles per gate window; legal range >= 2.
- ARM_CYCLES, 2, settle cycles after `enable` rises, before the first window starts; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- resetN  input  1  reset, synchronous and active-low.
- enable  input  1  1 = counting windows run; 0 = idle.
- pulseIn  input  1  asynchronous pulse source, counted on rising edges.
- validCount  output  WIDTH  count from the last completed window, saturated.
- countValid  output  1  one-cycle strobe, asserted in the cycle `validCount` takes a new value.
- overflow  output  1  1 = the last completed window saturated.
- windowActive  output  1  1 while in COUNT state.

Behaviour:
- Reset (resetN=0 at a clk edge):
  - state = IDLE; gateCnt = 0; count = 0; synchronizer flops = 0.
  - validCount = 0; countValid = 0; overflow = 0; windowActive = 0.
  - Reset overrides every other event, including mid-window.
- Synchronizer and edge detect:
  - pulseIn passes through 2 flops (s1, s2); s3 is a delayed copy of s2.
  - edge = s2 & ~s3.
  - A pulseIn rise that meets setup before edge N gives edge=1 during the cycle after edge N+1 (s2 captures the rise at N+1).
  - The count increments at edge N+2.
  - Minimum countable pulse: high >= 2 clk and low >= 2 clk.
- States: IDLE, ARM, COUNT.
- IDLE:
  - count = 0, gateCnt = 0; outputs hold.
  - enable=1 -> ARM, with gateCnt = 0.
- ARM:
  - gateCnt increments; edges are ignored, which flushes stale synchronizer state.
  - When gateCnt == ARM_CYCLES-1 -> COUNT, with gateCnt = 0 and count = 0.
  - enable=0 -> IDLE.
- COUNT:
  - gateCnt increments each cycle.
  - On edge, count = min(count+1, MAX).
  - When gateCnt == GATE_CYCLES-1 (last window cycle), at that clock edge:
    - validCount = min(count+edge, MAX); an edge in the last cycle belongs to this window.
    - overflow = 1 if the unsaturated total exceeded MAX, else 0.
    - countValid = 1 for exactly this next cycle.
    - count = 0, gateCnt = 0; stay in COUNT.
  - Windows are back-to-back with no dead cycle; with enable held, publications occur every GATE_CYCLES cycles.
  - enable=0 in any COUNT cycle -> IDLE; the partial window is discarded; validCount and overflow hold; no strobe.
- Saturation: count stops at MAX and never wraps; gateCnt wraps only by the explicit clear.
- countValid is 0 in every cycle except a publication cycle.
- windowActive = (state == COUNT), registered.
- Width: gateCnt is sized clog2(max(GATE_CYCLES, ARM_CYCLES)) bits; count is WIDTH bits, with the increment computed at WIDTH+1 bits for saturation detection.

Decomposition:
- Shared constants include file: state encodings (IDLE=2'd0, ARM=2'd1, COUNT=2'd2).
- One natural sub-module, `pulse_sync_edge`: 3-flop synchronizer plus rising-edge detect, with clk/resetN, output `edge`.
- The FSM, gate counter, saturating counter and output registers stay in `gated_pulse_counter`.

Test Plan:
- Reset: pulseIn toggling, resetN=0 for 3 cycles -> validCount=0, countValid=0, overflow=0, windowActive=0 throughout; after release with enable=1, windowActive rises 2 cycles later.
- Steady rate: GATE_CYCLES=16, pulseIn period 4 (2 high/2 low), enable held -> every window publishes validCount=4, overflow=0; countValid exactly one cycle wide, strobes 16 cycles apart.
- Saturation: WIDTH=3, GATE_CYCLES=32, pulseIn period 4 (8 edges) -> validCount=7, overflow=1; next window at period 8 (4 edges) -> validCount=4, overflow=0.
- Last-cycle boundary: single pulse timed so edge=1 when gateCnt=15 -> that window publishes 1; following window publishes 0.
- Enable drop: enable=0 at gateCnt=8 after a window published 4 -> no strobe; validCount stays 4; re-enable -> 2 ARM cycles, then a fresh 16-cycle window.
- Reset mid-window: resetN=0 for 1 cycle at gateCnt=10 with validCount=4 -> validCount=0 and state IDLE at the next edge; no strobe.

Source files
------------

// File: rtl/gated_pulse_counter_pkg.sv
// Shared state encoding and sizing helpers for the gated pulse counter.
package gated_pulse_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  // Larger of two integers, used to size the shared gate/arm counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gated_pulse_counter_sync.sv
// Brings the asynchronous pulse into clk and flags its rising edges.
module pulse_sync_edge (
  input  logic clk,
  input  logic resetN,
  input  logic pulse_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/gated_pulse_counter.sv
// Counts synchronized pulse edges over back-to-back gate windows and
// publishes each window's saturated total with a one-cycle strobe.
module gated_pulse_counter
  import gated_pulse_counter_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int GATE_CYCLES = 16,
  parameter int ARM_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             enable,
  input  logic             pulseIn,
  output logic [WIDTH-1:0] validCount,
  output logic             countValid,
  output logic             overflow,
  output logic             windowActive
);

  localparam int GC_TOP = max_int(GATE_CYCLES, ARM_CYCLES);
  localparam int GW     = (GC_TOP > 1) ? $clog2(GC_TOP) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] ARM_LAST  = GW'(ARM_CYCLES - 1);

  state_t           state_q, state_n;
  logic [GW-1:0]    gate_q, gate_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic             sat_q, sat_n;
  logic [WIDTH-1:0] vc_q, vc_n;
  logic             ov_q, ov_n;
  logic             cv_q, cv_n;
  logic             wa_q;
  logic             rise;
  logic [WIDTH:0]   inc;

  pulse_sync_edge u_sync (
    .clk      (clk),
    .resetN   (resetN),
    .pulse_in (pulseIn),
    .rise     (rise)
  );

  // One extra bit so a carry out of the count marks saturation.
  assign inc = {1'b0, count_q} + {{WIDTH{1'b0}}, rise};

  // State, counters and published outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      vc_q    <= '0;
      ov_q    <= 1'b0;
      cv_q    <= 1'b0;
      wa_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      gate_q  <= gate_n;
      count_q <= count_n;
      sat_q   <= sat_n;
      vc_q    <= vc_n;
      ov_q    <= ov_n;
      cv_q    <= cv_n;
      wa_q    <= (state_n == ST_COUNT);
    end
  end

  // Next-state and window bookkeeping; sat tracks edges lost to saturation.
  always_comb begin
    state_n = state_q;
    gate_n  = gate_q;
    count_n = count_q;
    sat_n   = sat_q;
    vc_n    = vc_q;
    ov_n    = ov_q;
    cv_n    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gate_n  = '0;
        count_n = '0;
        sat_n   = 1'b0;
        if (enable) state_n = ST_ARM;
      end
      ST_ARM: begin
        if (!enable) begin
          state_n = ST_IDLE;
          gate_n  = '0;
        end else if (gate_q == ARM_LAST) begin
          state_n = ST_COUNT;
          gate_n  = '0;
          count_n = '0;
          sat_n   = 1'b0;
        end else begin
          gate_n = gate_q + GW'(1);
        end
      end
      ST_COUNT: begin
        if (!enable) begin
          // Partial window is dropped; published values are left alone.
          state_n = ST_IDLE;
          gate_n  = '0;
          count_n = '0;
          sat_n   = 1'b0;
        end else if (gate_q == GATE_LAST) begin
          // An edge landing in the last cycle still belongs to this window.
          vc_n    = inc[WIDTH] ? {WIDTH{1'b1}} : inc[WIDTH-1:0];
          ov_n    = sat_q | inc[WIDTH];
          cv_n    = 1'b1;
          count_n = '0;
          gate_n  = '0;
          sat_n   = 1'b0;
        end else begin
          gate_n = gate_q + GW'(1);
          if (rise) begin
            if (inc[WIDTH]) sat_n = 1'b1;
            else            count_n = inc[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        gate_n  = '0;
        count_n = '0;
        sat_n   = 1'b0;
      end
    endcase
  end

  assign validCount   = vc_q;
  assign countValid   = cv_q;
  assign overflow     = ov_q;
  assign windowActive = wa_q;

endmodule
